// File: rtl/wishbone_ctrl_classic_if.sv
// Wishbone classic bus bundle. The controller drives cyc/stb/we/adr/dat_o.
// The device returns dat_i/ack_i.
interface wishbone_classic #(
  parameter int unsigned ADR_WIDTH = 8,
  parameter int unsigned DAT_WIDTH = 8
) ();
  logic                 clk_i;
  logic                 rst_i;
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;

  modport controller (
    input  clk_i, rst_i, dat_i, ack_i,
    output cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport device (
    input  clk_i, rst_i, cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wishbone_ctrl_classic.sv
// Single-transaction Wishbone classic controller (IDLE/CYCLE FSM, registered outputs).
// Define WISHBONE_CTRL_TIMEOUT_EN to abort a cycle after TIMEOUT edges without ack.
module wishbone_ctrl_classic #(
  parameter int unsigned ADR_WIDTH = 8,
  parameter int unsigned DAT_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  wishbone_classic.controller  wb,
  input  logic                 start,
  input  logic                 write_en,
  input  logic [ADR_WIDTH-1:0] addr,
  input  logic [DAT_WIDTH-1:0] write_data,
  output logic [DAT_WIDTH-1:0] read_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wishbone_ctrl_classic: TIMEOUT must be >= 2");
  end

  typedef enum logic {IDLE, CYCLE} state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DAT_WIDTH-1:0]   dat_q, dat_d;
  logic [DAT_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   done_q, done_d;

`ifdef WISHBONE_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // NOTE: every _d gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef WISHBONE_CTRL_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CYCLE;
          busy_d  = 1'b1;
          we_d    = write_en;
          adr_d   = addr;
          dat_d   = write_data;
`ifdef WISHBONE_CTRL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      CYCLE: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (wb.ack_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = wb.dat_i;
        end
`ifdef WISHBONE_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
`ifdef WISHBONE_CTRL_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
`ifdef WISHBONE_CTRL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign wb.cyc_o   = busy_q;
  assign wb.stb_o   = busy_q;
  assign wb.we_o    = we_q;
  assign wb.adr_o   = adr_q;
  assign wb.dat_o   = dat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign read_data  = rdata_q;
`ifdef WISHBONE_CTRL_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_ctrl_classic.sv
// Directed, table-driven bench for wishbone_ctrl_classic; inputs are driven 1 ns
// after each rising edge and outputs are compared at the same point.
module tb_wishbone_ctrl_classic;

  typedef struct packed {
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       start;
    logic       we;
    logic [7:0] adr;
    logic [7:0] wdat;
    logic       ack;
    logic [7:0] di;
    outs_t      exp;
  } vec_t;

  wishbone_classic #(.ADR_WIDTH(8), .DAT_WIDTH(8)) wb_if ();

  logic       start;
  logic       write_en;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_ctrl_classic #(.ADR_WIDTH(8), .DAT_WIDTH(8), .TIMEOUT(4)) dut (
    .wb         (wb_if),
    .start      (start),
    .write_en   (write_en),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial wb_if.clk_i = 1'b0;
  always #5 wb_if.clk_i = ~wb_if.clk_i;

  // Expected outputs; cyc, stb and busy always move together.
  function automatic outs_t o(input logic cyc, input logic we, input logic [7:0] adr,
                              input logic [7:0] dat, input logic [7:0] rdata,
                              input logic dn, input logic er);
    return '{cyc: cyc, stb: cyc, we: we, adr: adr, dat: dat, rdata: rdata,
             busy: cyc, done: dn, err: er};
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic st,
                              input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                              input logic ack, input logic [7:0] di, input outs_t exp);
    return '{name: name, rst: rst, start: st, we: we, adr: adr, wdat: wdat,
             ack: ack, di: di, exp: exp};
  endfunction

  function automatic outs_t sample();
    return '{cyc: wb_if.cyc_o, stb: wb_if.stb_o, we: wb_if.we_o, adr: wb_if.adr_o,
             dat: wb_if.dat_o, rdata: read_data, busy: busy, done: done, err: err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, let one rising edge pass, compare all outputs.
  task automatic step(input vec_t v);
    wb_if.rst_i = v.rst;
    start       = v.start;
    write_en    = v.we;
    addr        = v.adr;
    write_data  = v.wdat;
    wb_if.ack_i = v.ack;
    wb_if.dat_i = v.di;
    @(posedge wb_if.clk_i);
    #1;
    check(v.name, 32'(sample()), 32'(v.exp));
  endtask

  vec_t tbl[$];
  int   n_done;

  initial begin
    wb_if.rst_i = 1'b1;
    start       = 1'b0;
    write_en    = 1'b0;
    addr        = '0;
    write_data  = '0;
    wb_if.ack_i = 1'b0;
    wb_if.dat_i = '0;

    //                  name            rst st we adr    wdat   ack di        cyc we adr    dat    rdata  dn er
    tbl.push_back(mk("reset_prio",      1, 1, 1, 8'h44, 8'h55, 1, 8'h66, o(0, 0, 8'h00, 8'h00, 8'h00, 0, 0)));
    tbl.push_back(mk("reset_hold",      1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0, 0, 8'h00, 8'h00, 8'h00, 0, 0)));
    tbl.push_back(mk("idle_ack_ignore", 0, 0, 0, 8'h00, 8'h00, 1, 8'hFF, o(0, 0, 8'h00, 8'h00, 8'h00, 0, 0)));
    tbl.push_back(mk("rd_start",        0, 1, 0, 8'h12, 8'h77, 0, 8'h00, o(1, 0, 8'h12, 8'h77, 8'h00, 0, 0)));
    tbl.push_back(mk("rd_wait",         0, 0, 1, 8'h00, 8'h00, 0, 8'h3C, o(1, 0, 8'h12, 8'h77, 8'h00, 0, 0)));
    tbl.push_back(mk("rd_ack",          0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, o(0, 0, 8'h12, 8'h77, 8'hA5, 1, 0)));
    tbl.push_back(mk("rd_done_clear",   0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0, 0, 8'h12, 8'h77, 8'hA5, 0, 0)));
    tbl.push_back(mk("wr_start",        0, 1, 1, 8'h34, 8'h5A, 1, 8'h00, o(1, 1, 8'h34, 8'h5A, 8'hA5, 0, 0)));
    tbl.push_back(mk("wr_ack",          0, 0, 0, 8'h00, 8'h00, 1, 8'hEE, o(0, 1, 8'h34, 8'h5A, 8'hA5, 1, 0)));
    tbl.push_back(mk("wr_idle_hold",    0, 0, 0, 8'h00, 8'h00, 1, 8'hEE, o(0, 1, 8'h34, 8'h5A, 8'hA5, 0, 0)));
    tbl.push_back(mk("b2b1_start",      0, 1, 0, 8'h01, 8'h00, 1, 8'h11, o(1, 0, 8'h01, 8'h00, 8'hA5, 0, 0)));
    tbl.push_back(mk("b2b1_ack",        0, 1, 0, 8'h02, 8'h00, 1, 8'h11, o(0, 0, 8'h01, 8'h00, 8'h11, 1, 0)));
    tbl.push_back(mk("b2b2_start",      0, 1, 0, 8'h02, 8'h00, 1, 8'h22, o(1, 0, 8'h02, 8'h00, 8'h11, 0, 0)));
    tbl.push_back(mk("b2b2_ack",        0, 1, 0, 8'h03, 8'h00, 1, 8'h22, o(0, 0, 8'h02, 8'h00, 8'h22, 1, 0)));
    tbl.push_back(mk("b2b3_start",      0, 1, 0, 8'h03, 8'h00, 1, 8'h33, o(1, 0, 8'h03, 8'h00, 8'h22, 0, 0)));
    tbl.push_back(mk("b2b3_ack",        0, 0, 0, 8'h00, 8'h00, 1, 8'h33, o(0, 0, 8'h03, 8'h00, 8'h33, 1, 0)));
    tbl.push_back(mk("b2b_idle",        0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0, 0, 8'h03, 8'h00, 8'h33, 0, 0)));

    foreach (tbl[i]) step(tbl[i]);

    // Slow device: ack after 5 wait edges, with a second start attempted mid-cycle.
    n_done = 0;
    step(mk("slow_start", 0, 1, 1, 8'h56, 8'hC3, 0, 8'h00, o(1, 1, 8'h56, 8'hC3, 8'h33, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      step(mk($sformatf("slow_wait%0d", i), 0, (i == 2), 0, 8'h99, 8'h00, 0, 8'h88,
              o(1, 1, 8'h56, 8'hC3, 8'h33, 0, 0)));
      n_done += int'(done);
    end
    step(mk("slow_ack", 0, 0, 0, 8'h00, 8'h00, 1, 8'h88, o(0, 1, 8'h56, 8'hC3, 8'h33, 1, 0)));
    n_done += int'(done);
    step(mk("slow_after", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0, 1, 8'h56, 8'hC3, 8'h33, 0, 0)));
    n_done += int'(done);
    check("slow_done_count", 32'(n_done), 32'd1);

    // Reset two edges into a stalled read, with ack arriving at the reset edge.
    step(mk("stall_start", 0, 1, 0, 8'hAB, 8'hCD, 0, 8'h00, o(1, 0, 8'hAB, 8'hCD, 8'h33, 0, 0)));
    step(mk("stall_wait0", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1, 0, 8'hAB, 8'hCD, 8'h33, 0, 0)));
    step(mk("stall_wait1", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1, 0, 8'hAB, 8'hCD, 8'h33, 0, 0)));
    step(mk("stall_reset", 1, 1, 0, 8'h00, 8'h00, 1, 8'h5F, o(0, 0, 8'h00, 8'h00, 8'h00, 0, 0)));
    step(mk("stall_post",  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0, 0, 8'h00, 8'h00, 8'h00, 0, 0)));

`ifdef WISHBONE_CTRL_TIMEOUT_EN
    // TIMEOUT = 4: no ack aborts at the 4th edge; ack at the 4th edge completes normally.
    step(mk("to_start", 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, o(1, 0, 8'h10, 8'h00, 8'h00, 0, 0)));
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("to_wait%0d", i), 0, 0, 0, 8'h00, 8'h00, 0, 8'h77,
              o(1, 0, 8'h10, 8'h00, 8'h00, 0, 0)));
    step(mk("to_expire", 0, 0, 0, 8'h00, 8'h00, 0, 8'h77, o(0, 0, 8'h10, 8'h00, 8'h00, 1, 1)));
    step(mk("to_after",  0, 0, 0, 8'h00, 8'h00, 0, 8'h77, o(0, 0, 8'h10, 8'h00, 8'h00, 0, 0)));
    step(mk("to2_start", 0, 1, 0, 8'h20, 8'h00, 0, 8'h00, o(1, 0, 8'h20, 8'h00, 8'h00, 0, 0)));
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("to2_wait%0d", i), 0, 0, 0, 8'h00, 8'h00, 0, 8'h00,
              o(1, 0, 8'h20, 8'h00, 8'h00, 0, 0)));
    step(mk("to2_ack_wins", 0, 0, 0, 8'h00, 8'h00, 1, 8'h4D, o(0, 0, 8'h20, 8'h00, 8'h4D, 1, 0)));
`else
    // Without the timeout option a stalled cycle waits indefinitely and err stays low.
    step(mk("wait_start", 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, o(1, 0, 8'h10, 8'h00, 8'h00, 0, 0)));
    for (int i = 0; i < 20; i++)
      step(mk($sformatf("wait_stall%0d", i), 0, 0, 0, 8'h00, 8'h00, 0, 8'h77,
              o(1, 0, 8'h10, 8'h00, 8'h00, 0, 0)));
    step(mk("wait_ack", 0, 0, 0, 8'h00, 8'h00, 1, 8'h4D, o(0, 0, 8'h10, 8'h00, 8'h4D, 1, 0)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_ctrl_classic.md
WISHBONE_CTRL_CLASSIC -- requirements
Module: wishbone_ctrl_classic

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 8: address width.
REQ-002 SHALL have parameter DAT_WIDTH, default 8: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum wait, in cycles, for ack_i (used only under WISHBONE_CTRL_TIMEOUT_EN); legal range >= 2.
REQ-004 SHALL have the following ports, each listed as name, direction, width and meaning:
- wb.clk_i  in  1  the single clock, from the wishbone_classic.controller modport; all logic on rising edge.
- wb.rst_i  in  1  synchronous, active-high reset.
- start  in  1  request one transaction; sampled only in IDLE.
- write_en  in  1  1 = write, 0 = read; sampled with start.
- addr  in  ADR_WIDTH  transaction address; sampled with start.
- write_data  in  DAT_WIDTH  write payload; sampled with start.
- read_data  out  DAT_WIDTH  data captured from wb.dat_i on read completion.
- busy  out  1  high while a cycle is in progress.
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  one-cycle pulse on timeout abort.
- wb.cyc_o, wb.stb_o  out  1  bus cycle/strobe.
- wb.we_o  out  1  write enable.
- wb.adr_o  out  ADR_WIDTH  address.
- wb.dat_o  out  DAT_WIDTH  write data.
- wb.dat_i  in  DAT_WIDTH  read data from device.
- wb.ack_i  in  1  device acknowledge.

Function
REQ-005 SHALL implement a two-state FSM: IDLE and CYCLE; all outputs registered.
REQ-006 In IDLE, start high at edge k SHALL register write_en/addr/write_data onto wb.we_o/wb.adr_o/wb.dat_o, set wb.cyc_o = wb.stb_o = busy = 1 from edge k, and enter CYCLE.
REQ-007 In CYCLE, wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o and wb.dat_o SHALL remain stable until termination.
REQ-008 In CYCLE, wb.ack_i high at edge m SHALL clear wb.cyc_o/wb.stb_o/busy from edge m, pulse done for exactly the cycle after edge m, and return to IDLE.
REQ-009 On a read (wb.we_o = 0), edge m SHALL latch wb.dat_i into read_data; read_data SHALL hold until the next read completes; writes leave read_data unchanged.
REQ-010 start while busy SHALL be ignored (not queued); the earliest next acceptance is edge m+1, giving back-to-back transactions with a one-cycle bus gap.
REQ-011 A device with ack tied high SHALL complete in 2 edges (k, k+1); a registered-ack device SHALL complete in 3 edges (k, k+1, k+2).
REQ-012 wb.ack_i while in IDLE SHALL be ignored.
REQ-013 wb.we_o/wb.adr_o/wb.dat_o SHALL hold their last values in IDLE.

Reset
REQ-014 wb.rst_i high at an edge SHALL force IDLE, with wb.cyc_o = wb.stb_o = wb.we_o = 0, wb.adr_o = 0, wb.dat_o = 0, read_data = 0, busy = done = err = 0, and timeout counter = 0.
REQ-015 Reset mid-CYCLE SHALL abort the cycle without a done or err pulse; reset SHALL take priority over start and wb.ack_i at the same edge.

Configuration
REQ-016 With macro WISHBONE_CTRL_TIMEOUT_EN defined, the block SHALL include a counter, cleared on entry to CYCLE and incremented each CYCLE edge without ack.
REQ-017 With WISHBONE_CTRL_TIMEOUT_EN defined, reaching TIMEOUT edges in CYCLE without ack SHALL drop wb.cyc_o/wb.stb_o/busy, pulse err and done together for one cycle, leave read_data unchanged, and return to IDLE.
REQ-018 With WISHBONE_CTRL_TIMEOUT_EN defined, ack at the same edge as expiry SHALL win: normal completion, no err.
REQ-019 With WISHBONE_CTRL_TIMEOUT_EN undefined, err SHALL be tied to 0, no counter SHALL exist, TIMEOUT SHALL be ignored, and CYCLE SHALL wait indefinitely.

Verification
REQ-020 SHALL cover: read, addr=0x12, device acks 1 cycle after stb, wb.dat_i=0xA5 -> read_data=0xA5, done pulse 1 cycle, 3 edges total.
REQ-021 SHALL cover: write, addr=0x34, data=0x5A, ack tied 1 -> wb.we_o=1, wb.dat_o=0x5A for exactly one cycle, done at edge k+1, read_data unchanged.
REQ-022 SHALL cover: device delays ack 5 cycles; start pulsed again mid-cycle -> bus signals stable for the 5 cycles, second start ignored, exactly one done.
REQ-023 SHALL cover: back-to-back, start held high across 3 reads -> three transactions, each separated by exactly one idle bus cycle.
REQ-024 SHALL cover: wb.rst_i asserted 2 cycles into a stalled cycle -> wb.cyc_o = 0 next cycle, no done or err, all outputs at reset values.
REQ-025 SHALL cover, with WISHBONE_CTRL_TIMEOUT_EN and TIMEOUT=4: no ack -> cyc drops after 4 edges, err=done=1 for one cycle; ack at the 4th edge -> done only, err=0.
